// File: rtl/exe_fwd_ctrl_if.sv
// ID-stage request/branch signals and EXE forwarding/hazard responses for exe_fwd_ctrl.
// The master drives the ID side; the slave is the forwarding controller.
interface exe_fwd_ctrl_if;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [1:0] id_ra;
    logic [1:0] id_rb;
    logic [1:0] id_rd;
    logic       branch_taken;
    logic [1:0] fu_sel1;
    logic [1:0] fu_sel2;
    logic       stall;
    logic       flush;
    logic       ex_valid;
    logic [7:0] stall_count;

    modport master (
        output id_valid, id_opcode, id_ra, id_rb, id_rd, branch_taken,
        input  fu_sel1, fu_sel2, stall, flush, ex_valid, stall_count
    );

    modport slave (
        input  id_valid, id_opcode, id_ra, id_rb, id_rd, branch_taken,
        output fu_sel1, fu_sel2, stall, flush, ex_valid, stall_count
    );
endinterface

// File: rtl/exe_fwd_ctrl.sv
// EXE operand forwarding, load-use stall and branch flush control for a 4-register pipeline.
// Registered operand selects are resolved at issue from the EX and MEM producer tags.
module exe_fwd_ctrl #(
    parameter logic [15:0] WB_OPS = 16'b1010_0001_0011_1110
) (
    input  logic          clk,
    input  logic          reset,
    exe_fwd_ctrl_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic [1:0] rd;
        logic       wr;
        logic       ld;
    } tag_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH1 = 2'd1,
        FLUSH2 = 2'd2
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b1101;

    state_t     state_q, state_d;
    tag_t       ex_q, mem_q, ex_d;
    logic [1:0] sel1_q, sel1_d;
    logic [1:0] sel2_q, sel2_d;
    logic [7:0] cnt_q, cnt_d;

    logic       reads_a, reads_b;
    logic       hazard, flush_w, stall_w, issue;

    // WB tag is not kept: a producer in WB is already visible through the regfile.
    always_comb begin
        reads_a = 1'b0;
        reads_b = 1'b0;
        case (bus.id_opcode)
            4'd1, 4'd2, 4'd3:     begin reads_a = 1'b1; reads_b = 1'b1; end
            4'd4, 4'd5, 4'd6:     reads_a = 1'b1;
            4'd8:                 reads_b = 1'b1;
            4'd14:                begin reads_a = 1'b1; reads_b = 1'b1; end
            default:              ;
        endcase
    end

    assign hazard = bus.id_valid & ex_q.valid & ex_q.ld &
                    ((reads_a & (ex_q.rd == bus.id_ra)) |
                     (reads_b & (ex_q.rd == bus.id_rb)));

    always_comb begin
        state_d = state_q;
        flush_w = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.branch_taken) begin
                    flush_w = 1'b1;
                    state_d = FLUSH1;
                end
            end
            FLUSH1: begin
                flush_w = 1'b1;
                state_d = FLUSH2;
            end
            FLUSH2: begin
                if (bus.branch_taken) begin
                    flush_w = 1'b1;
                    state_d = FLUSH1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_w = hazard & ~flush_w & ~reset;
    assign issue   = bus.id_valid & ~stall_w & ~flush_w;

    always_comb begin
        ex_d   = '0;
        sel1_d = 2'b00;
        sel2_d = 2'b00;
        cnt_d  = cnt_q;
        if (issue) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = bus.id_rd;
            ex_d.wr    = WB_OPS[bus.id_opcode];
            ex_d.ld    = (bus.id_opcode == OP_LOAD);
            if (reads_a) begin
                if (ex_q.valid & ex_q.wr & (ex_q.rd == bus.id_ra))
                    sel1_d = 2'b10;
                else if (mem_q.valid & mem_q.wr & (mem_q.rd == bus.id_ra))
                    sel1_d = 2'b01;
            end
            if (reads_b) begin
                if (ex_q.valid & ex_q.wr & (ex_q.rd == bus.id_rb))
                    sel2_d = 2'b10;
                else if (mem_q.valid & mem_q.wr & (mem_q.rd == bus.id_rb))
                    sel2_d = 2'b01;
            end
        end
        if (stall_w && cnt_q != '1)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fu_sel1     = sel1_q;
    assign bus.fu_sel2     = sel2_q;
    assign bus.stall       = stall_w;
    assign bus.flush       = flush_w & ~reset;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.stall_count = cnt_q;

endmodule

// File: doc/exe_fwd_ctrl.md
EXE_FWD_CTRL -- requirements
Module: exe_fwd_ctrl

Interface
REQ-001 The block SHALL have parameter WB_OPS, default 16'b1010_0001_0011_1110, meaning a bitmask indexed by opcode; bit set = opcode writes Rd (ADD, SUB, NAND, SHL, SHR, MOV, LOAD, LOADIMM).
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port id_valid, input, 1 bit: instruction present in ID.
REQ-005 The block SHALL have port id_opcode, input, 4 bits: ID opcode (ALU encoding: NOP 0000 ... LOADIMM 1111).
REQ-006 The block SHALL have ports id_ra, id_rb and id_rd, inputs, 2 bits each: ID source and destination register indices.
REQ-007 The block SHALL have port branch_taken, input, 1 bit: taken branch resolved this cycle.
REQ-008 The block SHALL have ports fu_sel1 and fu_sel2, outputs, 2 bits each: EXE operand mux selects (00 regfile, 01 WB, 10 DM, 11 never driven).
REQ-009 The block SHALL have port stall, output, 1 bit: hold PC and IF/ID this cycle.
REQ-010 The block SHALL have port flush, output, 1 bit: squash IF/ID this cycle.
REQ-011 The block SHALL have port ex_valid, output, 1 bit: EX holds a real instruction (not a bubble).
REQ-012 The block SHALL have port stall_count, output, 8 bits: saturating count of load-use stall cycles.

Function
REQ-013 Track three stage tags EX, MEM and WB, each holding {valid, rd[1:0], wr, ld}; wr = WB_OPS[opcode]; ld = (opcode==1101).
REQ-014 Read sets: Ra read by 0001-0110 and 1110; Rb read by 0001-0011, 1000 and 1110; all other opcodes read nothing.
REQ-015 Each clock edge (not stalled): WB<=MEM, MEM<=EX, EX<=issued ID tag, or a bubble (valid=0) when !id_valid, stall or flush.
REQ-016 fu_selN SHALL be registered, computed at the issue edge for each read operand: 10 if old EX tag valid&wr&rd match; else 01 if old MEM tag valid&wr&rd match; else 00.
REQ-017 MEM match SHALL take priority over WB match (newest producer wins).
REQ-018 An operand not read, or a bubble issued, SHALL yield fu_selN=00.
REQ-019 Load-use hazard = id_valid & EX tag valid & ld & (operand read with rd match); stall=1 combinationally that cycle; a bubble enters EX; IF/ID is held.
REQ-020 Load-use stall SHALL last exactly 1 cycle; afterwards the load is in MEM and the consumer issues with fu_sel=01.
REQ-021 FSM states RUN, FLUSH1, FLUSH2.
REQ-022 FSM transitions: RUN -> FLUSH1 on branch_taken; FLUSH1 -> FLUSH2; FLUSH2 -> RUN, or FLUSH1 if branch_taken again.
REQ-023 flush=1 when branch_taken, or while in FLUSH1; bubbles enter EX.
REQ-024 flush SHALL override stall (stall=0 when flush=1), and branch_taken SHALL be ignored while in FLUSH1.
REQ-025 stall_count SHALL increment on each stall cycle and saturate at 8'hFF with no wrap.
REQ-026 ex_valid SHALL equal the EX tag valid bit.
REQ-027 Bubbles SHALL never match for forwarding or hazard detection.

Reset
REQ-028 On reset all stage tags SHALL be invalid, the FSM SHALL be in RUN, and fu_sel1=fu_sel2=00, stall=0, flush=0, ex_valid=0, stall_count=0.
REQ-029 reset SHALL take priority over every other input, including assertion mid-stall or mid-flush.
REQ-030 In the first cycle after reset deassertion, forwarding SHALL produce no matches.

Verification
REQ-031 ADD r1 then ADD r2,r1,r3 back-to-back -> second instruction in EX has fu_sel1=10, fu_sel2=00.
REQ-032 ADD r1, NOP, SUB r2,r0,r1 -> SUB in EX has fu_sel2=01; also ADD r1, ADD r1, MOV r2,r1 -> fu_sel2=10 (newest producer wins).
REQ-033 LOAD r2 then NAND r3,r2,r2 -> stall=1 for exactly one cycle, ex_valid=0 that cycle, NAND has fu_sel1=fu_sel2=01, stall_count=1.
REQ-034 branch_taken pulse concurrent with a load-use hazard -> flush=1 for 2 cycles, stall=0, stall_count unchanged, FSM returns to RUN.
REQ-035 Force 300 load-use stalls -> stall_count=8'hFF; assert reset during FLUSH1 -> next cycle all outputs 0 and FSM in RUN.
